// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the multi-cycle RV32I control unit:
//   - state_t        : controller sequencing states
//   - OPC_*          : major opcode values (IR[6:0])
//   - ALU_*          : 4-bit ALU operation codes driven on alu_op
//   - PC_SRC_*, ALU_A_*, ALU_B_*, WB_* : datapath mux select encodings
//   - CAUSE_*        : trap_cause encodings
//   - is_known_opcode / branch_taken : small decode helpers
// ----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JALR   = 2'd2;

  localparam logic [1:0] ALU_A_PC   = 2'd0;
  localparam logic [1:0] ALU_A_RS1  = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic [1:0] ALU_B_RS2  = 2'd0;
  localparam logic [1:0] ALU_B_FOUR = 2'd1;
  localparam logic [1:0] ALU_B_IMM  = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  function automatic logic is_known_opcode(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // Only signed compares exist in the ALU; unsupported branch funct3
  // values never redirect the PC.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       zero,
                                        input logic       lt);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu_dec.sv
// ----------------------------------------------------------------------------
// riscv_alu_dec
// Combinational funct3/funct7 decode to the 4-bit ALU operation for
// register-register and register-immediate arithmetic.
// Ports:
//   funct3    in  3  IR[14:12]
//   funct7_b5 in  1  IR[30], selects SUB / SRA
//   is_r_type in  1  instruction is OP (register-register)
//   alu_op    out 4  ALU operation code
// ----------------------------------------------------------------------------
module riscv_alu_dec
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       is_r_type,
  output logic [3:0] alu_op
);

  // SUB exists only as a register-register op (ADDI's IR[30] is immediate
  // data), while SRA is selected by IR[30] for both SRA and SRAI.
  // SLTU has no dedicated ALU code and shares the SLT compare.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000: alu_op = (is_r_type && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_op = ALU_SLL;
      3'b010: alu_op = ALU_SLT;
      3'b011: alu_op = ALU_SLT;
      3'b100: alu_op = ALU_XOR;
      3'b101: alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_op = ALU_OR;
      3'b111: alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// ----------------------------------------------------------------------------
// riscv_mc_ctrl
// Multi-cycle control unit for the RV32I core. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, handshakes with the shared memory port
// (with a wait-state timeout) and drives every datapath enable and select.
//
// Parameters:
//   MAX_WAIT  memory wait cycles tolerated before a timeout trap (1..255)
//
// Build option:
//   RISCV_PERF_CNT_EN  when defined, builds cycle_cnt / instret_cnt
//                      counters; otherwise both outputs read 0.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   opcode, funct3, funct7      instruction fields from IR
//   alu_zero, alu_lt            ALU status
//   mem_ready                   memory completes the current request
//   mem_req, mem_we, addr_sel   memory port control
//   ir_write, pc_write, pc_src  IR / PC update control
//   alu_src_a, alu_src_b, alu_op ALU operand selects and operation
//   reg_write, wb_sel           register file write control
//   instr_done                  one-cycle retire pulse
//   trap, trap_cause            sticky halt flag and reason
//   cycle_cnt, instret_cnt      performance counters
// ----------------------------------------------------------------------------
module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        instr_done,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              trap_q;
  logic [1:0]        trap_cause_q;
  logic [3:0]        dec_alu_op;
  logic              is_load;
  logic              is_store;
  logic              is_branch;
  logic              is_jal;
  logic              is_jalr;
  logic              wait_expired;
  logic              unused_funct7;

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);

  // The counter holds the number of unanswered cycles already spent, so the
  // MAX_WAIT-th unanswered cycle is the one that sees MAX_WAIT-1 here.
  assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  // Only IR[30] steers the ALU decode; the other funct7 bits are immediate
  // or reserved and intentionally ignored.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  riscv_alu_dec u_alu_dec (
    .funct3    (funct3),
    .funct7_b5 (funct7[5]),
    .is_r_type (opcode == OPC_OP),
    .alu_op    (dec_alu_op)
  );

  // Sequencer. The wait counter defaults to clearing every cycle and only
  // counts while a memory request is pending without ready; a same-cycle
  // mem_ready always beats the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_FETCH;
      wait_cnt     <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      wait_cnt <= '0;
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end else if (wait_expired) begin
            state        <= ST_TRAP;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: begin
          if (!is_known_opcode(opcode)) begin
            state        <= ST_TRAP;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_ILLEGAL;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_load || is_store) begin
            state <= ST_MEM;
          end else if (is_branch || is_jal || is_jalr) begin
            state <= ST_FETCH;
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            state <= is_store ? ST_FETCH : ST_WB;
          end else if (wait_expired) begin
            state        <= ST_TRAP;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Datapath control is decoded from the current state plus the handshake
  // and ALU status inputs, so strobes land in the same cycle as the event.
  // mem_req is additionally masked by reset so an abandoned request drops
  // the instant reset asserts.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = ALU_A_PC;
    alu_src_b  = ALU_B_RS2;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    wb_sel     = WB_ALUOUT;
    instr_done = 1'b0;

    case (state)
      ST_FETCH: begin
        mem_req   = !reset;
        alu_src_a = ALU_A_PC;
        alu_src_b = ALU_B_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        pc_src    = PC_SRC_ALU;
      end
      ST_DECODE: begin
        // PC already advanced, but the datapath presents the old PC here so
        // ALUOut captures the branch/JAL target.
        alu_src_a = ALU_A_PC;
        alu_src_b = ALU_B_IMM;
        alu_op    = ALU_ADD;
      end
      ST_EXEC: begin
        case (opcode)
          OPC_OP: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_RS2;
            alu_op    = dec_alu_op;
          end
          OPC_OPIMM: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_IMM;
            alu_op    = dec_alu_op;
          end
          OPC_LUI: begin
            alu_src_a = ALU_A_ZERO;
            alu_src_b = ALU_B_IMM;
          end
          OPC_AUIPC: begin
            alu_src_a = ALU_A_PC;
            alu_src_b = ALU_B_IMM;
          end
          OPC_LOAD, OPC_STORE: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_IMM;
          end
          OPC_BRANCH: begin
            alu_src_a  = ALU_A_RS1;
            alu_src_b  = ALU_B_RS2;
            alu_op     = ALU_SUB;
            pc_write   = branch_taken(funct3, alu_zero, alu_lt);
            pc_src     = PC_SRC_ALUOUT;
            instr_done = 1'b1;
          end
          OPC_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_ALUOUT;
            reg_write  = 1'b1;
            wb_sel     = WB_PC;
            instr_done = 1'b1;
          end
          OPC_JALR: begin
            alu_src_a  = ALU_A_RS1;
            alu_src_b  = ALU_B_IMM;
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JALR;
            reg_write  = 1'b1;
            wb_sel     = WB_PC;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req    = !reset;
        addr_sel   = 1'b1;
        mem_we     = is_store;
        instr_done = is_store && mem_ready;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        wb_sel     = is_load ? WB_MDR : WB_ALUOUT;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

`ifdef RISCV_PERF_CNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // Free-running wrapping counters; cycle counting freezes once halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != ST_TRAP) begin
        cycle_q <= cycle_q + 32'd1;
      end
      if (instr_done) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_riscv_mc_ctrl
// Self-checking bench for riscv_mc_ctrl. Each instruction is expanded into a
// per-cycle schedule of expected control outputs derived from the
// instruction-level rules (phases, wait states, branch outcome), then
// replayed against the controller one cycle at a time.
// ----------------------------------------------------------------------------
module tb_riscv_mc_ctrl;

  localparam int MAX_WAIT = 15;

  localparam logic [6:0] O_LOAD   = 7'b0000011;
  localparam logic [6:0] O_STORE  = 7'b0100011;
  localparam logic [6:0] O_OP     = 7'b0110011;
  localparam logic [6:0] O_OPIMM  = 7'b0010011;
  localparam logic [6:0] O_BRANCH = 7'b1100011;
  localparam logic [6:0] O_JAL    = 7'b1101111;
  localparam logic [6:0] O_JALR   = 7'b1100111;
  localparam logic [6:0] O_LUI    = 7'b0110111;
  localparam logic [6:0] O_AUIPC  = 7'b0010111;

  localparam logic [3:0] A_AND = 4'b0000, A_OR  = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_XOR = 4'b0011, A_SLL = 4'b0100, A_SRL = 4'b0101;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_SRA = 4'b1000;

  localparam int K_R = 0, K_I = 1, K_LUI = 2, K_AUIPC = 3, K_LOAD = 4;
  localparam int K_STORE = 5, K_BR = 6, K_JAL = 7, K_JALR = 8;

  typedef struct packed {
    logic        ready;
    logic        counted;
    logic        done;
    logic [21:0] exp;
    logic [21:0] care;
  } step_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        alu_zero = 1'b0;
  logic        alu_lt = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel, trap_cause;
  logic [3:0]  alu_op;
  logic        reg_write, instr_done, trap;
  logic [31:0] cycle_cnt, instret_cnt;

  int    checks = 0;
  int    failures = 0;
  int    model_cycles = 0;
  int    model_retired = 0;
  step_t sched[$];

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic [6:0] cur_f7;
  logic       cur_z, cur_lt;
  string      cur_tag;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_zero    (alu_zero),
    .alu_lt      (alu_lt),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .addr_sel    (addr_sel),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .instr_done  (instr_done),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  function automatic logic [21:0] po(input logic mreq, mwe, asel, irw, pcw,
                                     input logic [1:0] pcs, sa, sb,
                                     input logic [3:0] aop,
                                     input logic rw, input logic [1:0] wbs,
                                     input logic done, tr,
                                     input logic [1:0] tc);
    return {mreq, mwe, asel, irw, pcw, pcs, sa, sb, aop, rw, wbs, done, tr, tc};
  endfunction

  function automatic logic [21:0] observed();
    return po(mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, alu_src_a,
              alu_src_b, alu_op, reg_write, wb_sel, instr_done, trap, trap_cause);
  endfunction

  // Selects are only compared where the rules give them meaning.
  function automatic step_t mk(input logic rdy, cnt, mreq, mwe, asel, irw, pcw,
                               input logic [1:0] pcs, sa, sb,
                               input logic [3:0] aop,
                               input logic rw, input logic [1:0] wbs,
                               input logic done, tr, input logic [1:0] tc,
                               input logic ac);
    step_t s;
    s.ready   = rdy;
    s.counted = cnt;
    s.done    = done;
    s.exp     = po(mreq, mwe, asel, irw, pcw, pcs, sa, sb, aop, rw, wbs, done, tr, tc);
    s.care    = po(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, pcw ? 2'b11 : 2'b00,
                   ac ? 2'b11 : 2'b00, ac ? 2'b11 : 2'b00, ac ? 4'hf : 4'h0,
                   1'b1, rw ? 2'b11 : 2'b00, 1'b1, 1'b1, 2'b11);
    return s;
  endfunction

  function automatic logic rnd();
    return ($urandom & 1) != 0;
  endfunction

  function automatic logic [3:0] refAlu(input logic [2:0] f3, input logic [6:0] f7,
                                        input logic r_type);
    case (f3)
      3'd0:    return (r_type && f7[5]) ? A_SUB : A_ADD;
      3'd1:    return A_SLL;
      3'd2:    return A_SLT;
      3'd4:    return A_XOR;
      3'd5:    return f7[5] ? A_SRA : A_SRL;
      3'd6:    return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic logic refTaken(input logic [2:0] f3, input logic z, lt);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      default: return !lt;
    endcase
  endfunction

  function automatic logic [6:0] opcodeOf(input int kind);
    case (kind)
      K_R:     return O_OP;
      K_I:     return O_OPIMM;
      K_LUI:   return O_LUI;
      K_AUIPC: return O_AUIPC;
      K_LOAD:  return O_LOAD;
      K_STORE: return O_STORE;
      K_BR:    return O_BRANCH;
      K_JAL:   return O_JAL;
      default: return O_JALR;
    endcase
  endfunction

  task automatic applyStimulus(input logic rdy);
    mem_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkCounters(input string tag);
`ifdef RISCV_PERF_CNT_EN
    checkOutput({tag, "_cycle_cnt"}, cycle_cnt, model_cycles);
    checkOutput({tag, "_instret_cnt"}, instret_cnt, model_retired);
`else
    checkOutput({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
    checkOutput({tag, "_instret_cnt"}, instret_cnt, 32'd0);
`endif
  endtask

  task automatic pushFetch(input int fw, input logic with_ready);
    for (int i = 0; i < fw; i++)
      sched.push_back(mk(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0,
                         0, 2'd0, 0, 0, 2'd0, 1'b0));
    if (with_ready)
      sched.push_back(mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, A_ADD,
                         0, 2'd0, 0, 0, 2'd0, 1'b1));
  endtask

  task automatic pushDecode();
    sched.push_back(mk(rnd(), 1'b1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, A_ADD,
                       0, 2'd0, 0, 0, 2'd0, 1'b1));
  endtask

  task automatic pushMem(input logic store, input int mw);
    for (int i = 0; i < mw; i++)
      sched.push_back(mk(1'b0, 1'b1, 1'b1, store, 1'b1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0,
                         0, 2'd0, 0, 0, 2'd0, 1'b0));
    sched.push_back(mk(1'b1, 1'b1, 1'b1, store, 1'b1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0,
                       0, 2'd0, store, 0, 2'd0, 1'b0));
  endtask

  task automatic pushWb(input logic load);
    sched.push_back(mk(rnd(), 1'b1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0,
                       1'b1, load ? 2'd1 : 2'd0, 1'b1, 0, 2'd0, 1'b0));
  endtask

  task automatic pushTrap(input int n, input logic [1:0] cause);
    for (int i = 0; i < n; i++)
      sched.push_back(mk(rnd(), 1'b0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0,
                         0, 2'd0, 0, 1'b1, cause, 1'b0));
  endtask

  task automatic pushExec(input int kind);
    logic tk;
    case (kind)
      K_R:     sched.push_back(mk(rnd(), 1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0,
                                  refAlu(cur_f3, cur_f7, 1'b1), 0, 2'd0, 0, 0, 2'd0, 1));
      K_I:     sched.push_back(mk(rnd(), 1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2,
                                  refAlu(cur_f3, cur_f7, 1'b0), 0, 2'd0, 0, 0, 2'd0, 1));
      K_LUI:   sched.push_back(mk(rnd(), 1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, A_ADD,
                                  0, 2'd0, 0, 0, 2'd0, 1));
      K_AUIPC: sched.push_back(mk(rnd(), 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, A_ADD,
                                  0, 2'd0, 0, 0, 2'd0, 1));
      K_LOAD, K_STORE:
               sched.push_back(mk(rnd(), 1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, A_ADD,
                                  0, 2'd0, 0, 0, 2'd0, 1));
      K_BR: begin
        tk = refTaken(cur_f3, cur_z, cur_lt);
        sched.push_back(mk(rnd(), 1, 0, 0, 0, 0, tk, 2'd1, 2'd1, 2'd0, A_SUB,
                           0, 2'd0, 1, 0, 2'd0, 1));
      end
      K_JAL:   sched.push_back(mk(rnd(), 1, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 4'd0,
                                  1, 2'd2, 1, 0, 2'd0, 0));
      default: sched.push_back(mk(rnd(), 1, 0, 0, 0, 0, 1, 2'd2, 2'd1, 2'd2, A_ADD,
                                  1, 2'd2, 1, 0, 2'd0, 1));
    endcase
  endtask

  // Replays the schedule; max_steps >= 0 abandons it mid-way (used before a
  // reset), otherwise the final clock edge of the last step is consumed.
  task automatic runSched(input int max_steps);
    step_t s;
    int    n = 0;
    while (sched.size() > 0 && (max_steps < 0 || n < max_steps)) begin
      s = sched.pop_front();
      @(negedge clk);
      if (n == 0) begin
        opcode   = cur_op;
        funct3   = cur_f3;
        funct7   = cur_f7;
        alu_zero = cur_z;
        alu_lt   = cur_lt;
      end
      applyStimulus(s.ready);
      #1;
      checkOutput($sformatf("%s_c%0d", cur_tag, n), {10'd0, observed() & s.care},
                  {10'd0, s.exp & s.care});
      if (s.counted) model_cycles++;
      if (s.done) model_retired++;
      n++;
    end
    if (max_steps < 0) begin
      @(posedge clk);
      #1;
    end
    sched.delete();
  endtask

  task automatic setInstr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic z, lt);
    cur_tag = tag;
    cur_op  = op;
    cur_f3  = f3;
    cur_f7  = f7;
    cur_z   = z;
    cur_lt  = lt;
  endtask

  task automatic buildInstr(input int kind, input int fw, input int mw);
    pushFetch(fw, 1'b1);
    pushDecode();
    pushExec(kind);
    case (kind)
      K_R, K_I, K_LUI, K_AUIPC: pushWb(1'b0);
      K_LOAD: begin
        pushMem(1'b0, mw);
        pushWb(1'b1);
      end
      K_STORE: pushMem(1'b1, mw);
      default: ;
    endcase
  endtask

  task automatic runInstr(input string tag, input int kind, input logic [2:0] f3,
                          input logic [6:0] f7, input logic z, lt,
                          input int fw, input int mw);
    setInstr(tag, opcodeOf(kind), f3, f7, z, lt);
    buildInstr(kind, fw, mw);
    runSched(-1);
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    checkOutput({tag, "_mem_req_drop"}, {31'd0, mem_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_cycles  = 0;
    model_retired = 0;
    #1;
    checkOutput({tag, "_idle"},
                {10'd0, observed() & po(1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 2'b11)},
                {10'd0, po(1'b1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0, 0, 2'd0, 0, 0, 2'd0)});
    checkCounters({tag, "_cnt"});
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          kind;
    logic [2:0]  f3;
    logic [2:0]  alu_f3s [7];
    logic [2:0]  br_f3s  [4];

    alu_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    br_f3s  = '{3'd0, 3'd1, 3'd4, 3'd5};

    #2;
    doReset("por");

    runInstr("add0", K_R, 3'd0, 7'd0, 0, 0, 0, 0);
    for (int i = 1; i < 10; i++)
      runInstr($sformatf("add%0d", i), K_R, 3'd0, 7'd0, 0, 0, 0, 0);
    checkCounters("ten_adds");

    runInstr("sub",      K_R,     3'd0, 7'b0100000, 0, 0, 0, 0);
    runInstr("addi_b30", K_I,     3'd0, 7'b0100000, 0, 0, 0, 0);
    runInstr("srai",     K_I,     3'd5, 7'b0100000, 0, 0, 0, 0);
    runInstr("lw_wait3", K_LOAD,  3'd2, 7'd0, 0, 0, 0, 3);
    runInstr("beq_t",    K_BR,    3'd0, 7'd0, 1, 0, 0, 0);
    runInstr("beq_nt",   K_BR,    3'd0, 7'd0, 0, 0, 0, 0);
    runInstr("jal",      K_JAL,   3'd0, 7'd0, 0, 0, 0, 0);
    runInstr("jalr",     K_JALR,  3'd0, 7'd0, 0, 0, 0, 0);
    runInstr("lui",      K_LUI,   3'd0, 7'd0, 0, 0, 0, 0);
    runInstr("auipc",    K_AUIPC, 3'd0, 7'd0, 0, 0, 0, 0);
    runInstr("fetch_w14", K_R,    3'd4, 7'd0, 0, 0, MAX_WAIT - 1, 0);
    runInstr("sw_w14",   K_STORE, 3'd2, 7'd0, 0, 0, 0, MAX_WAIT - 1);
    checkCounters("directed");

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 8));
      if (kind == K_BR) f3 = br_f3s[$urandom_range(0, 3)];
      else              f3 = alu_f3s[$urandom_range(0, 6)];
      runInstr($sformatf("rnd%0d_k%0d", i, kind), kind, f3, 7'($urandom),
               rnd(), rnd(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    checkCounters("random");

    // Abandon a load while its data request is outstanding.
    setInstr("lw_abort", O_LOAD, 3'd2, 7'd0, 0, 0);
    buildInstr(K_LOAD, 0, 5);
    runSched(5);
    doReset("mid_req");

    runInstr("after_abort", K_R, 3'd7, 7'd0, 0, 0, 0, 0);

    // Undefined opcode halts one cycle after DECODE and stays halted.
    setInstr("illegal", 7'b1111111, 3'd0, 7'd0, 0, 0);
    pushFetch(0, 1'b1);
    pushDecode();
    pushTrap(20, 2'd1);
    runSched(-1);
    checkCounters("illegal");
    doReset("clr_illegal");

    // Instruction fetch never answered.
    setInstr("timeout", O_OP, 3'd0, 7'd0, 0, 0);
    pushFetch(MAX_WAIT, 1'b0);
    pushTrap(5, 2'd2);
    runSched(-1);
    checkCounters("timeout");
    doReset("clr_timeout");

    runInstr("recover", K_STORE, 3'd2, 7'd0, 0, 0, 1, 1);
    checkCounters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
Multi-cycle control unit for the next-generation RV32I core, replacing the single-cycle Controller/ALUController pair.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Talks to a shared instruction/data memory over a req/ready handshake with a wait-state timeout.
- Drives all datapath enables, mux selects and the 4-bit ALU operation.
- Sits between the register/ALU datapath and the memory port in the riscv top.

Parameters:
MAX_WAIT, 15, memory wait cycles tolerated before timeout trap (1..255)
WAIT_W, $clog2(MAX_WAIT+1), wait-counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
opcode  in  7  IR[6:0], valid from DECODE onward
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
alu_zero  in  1  ALU result == 0
alu_lt  in  1  signed a<b (from ALU compare)
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write when mem_req; 0 in FETCH
addr_sel  out  1  0=PC, 1=ALUOut
ir_write  out  1  load IR from memory data
pc_write  out  1  PC update enable
pc_src  out  2  0=ALU result, 1=ALUOut, 2=ALU result & ~1 (JALR)
alu_src_a  out  2  0=PC, 1=rs1, 2=zero
alu_src_b  out  2  0=rs2, 1=const 4, 2=imm
alu_op  out  4  operation code, riscv_pkg encoding
reg_write  out  1  register file write enable
wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC (return address)
instr_done  out  1  one-cycle pulse when an instruction retires
trap  out  1  sticky; core halted
trap_cause  out  2  0=none, 1=illegal opcode, 2=memory timeout
cycle_cnt  out  32  see Optional Feature
instret_cnt  out  32  see Optional Feature

Behaviour:
- Reset (async): state=FETCH, wait counter=0, trap=0, trap_cause=0, counters=0. Every output is a pure function of state plus inputs (Moore except handshake terms), so all strobes read 0 except mem_req=1, addr_sel=0 in FETCH.
- FETCH:
  - mem_req=1, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, ALU computes PC+4 (src_a=0, src_b=1, ADD); go to DECODE.
- DECODE:
  - ALU computes PC_old+imm into ALUOut for branch/JAL targets (datapath keeps old PC).
  - Unknown opcode: go to TRAP, cause=1.
  - Otherwise go to EXEC.
- EXEC:
  - R/I-type: alu_op from funct3/funct7; SUB/SRA only when funct7[5]=1 and the instruction is R-type (SRAI also allowed). Go to WB.
  - LUI: src_a=2, src_b=2. AUIPC: src_a=0, src_b=2. Both go to WB.
  - LOAD/STORE: rs1+imm, then MEM.
  - BRANCH: alu_op=SUB. Taken per funct3: BEQ zero, BNE !zero, BLT lt, BGE !lt. If taken, pc_write=1, pc_src=1. instr_done=1; go to FETCH.
  - JAL: pc_write, pc_src=1, reg_write, wb_sel=2, instr_done; go to FETCH.
  - JALR: src_a=1, src_b=2, pc_src=2, pc_write, reg_write, wb_sel=2, instr_done; go to FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=store.
  - On mem_ready: store sets instr_done and goes to FETCH; load goes to WB.
- WB: reg_write=1, wb_sel=1 for load else 0, instr_done=1; go to FETCH.
- Latency with zero-wait memory: branch 3 cycles; R/I/LUI/AUIPC/JAL/JALR/store 3–4 cycles; load 5 cycles.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ready=0, and clears on mem_ready or state change.
  - Reaching MAX_WAIT without ready: TRAP, cause=2. mem_ready in that same cycle wins (no trap).
- TRAP: all strobes 0, mem_req=0, trap=1. Left only by reset.
- Reset mid-request drops mem_req immediately; memory must tolerate an abandoned request.

Optional Feature:
RISCV_PERF_CNT_EN
- Defined: cycle_cnt increments every cycle outside TRAP; instret_cnt increments on instr_done. Both are 32-bit wrapping counters and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- riscv_pkg holds:
  - state enum
  - opcode constants (LOAD 0000011, STORE 0100011, OP 0110011, OPIMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111)
  - alu_op codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000
  - pc_src/alu_src/wb_sel/trap_cause encodings
- One sub-module, riscv_alu_dec: combinational funct3/funct7 to alu_op decode.

Test Plan:
- ADD x3,x1,x2 with mem_ready tied 1 → states FETCH,DECODE,EXEC,WB; reg_write in cycle 4, instr_done exactly once.
- LW with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles, addr_sel=1, mem_we=0, reg_write with wb_sel=1 after ready.
- BEQ with alu_zero=1, then alu_zero=0 → pc_write=1/pc_src=1 vs pc_write=0; both return to FETCH after 3 cycles.
- Opcode 1111111 → trap=1, trap_cause=1 one cycle after DECODE; mem_req stays 0 for 20 cycles; reset clears it.
- mem_ready held 0 in FETCH with MAX_WAIT=15 → trap_cause=2 after 15 cycles; ready asserted on cycle 15 → no trap.
- With RISCV_PERF_CNT_EN, 10 ADDs at zero wait → instret_cnt=10, cycle_cnt=40.
